// File: rtl/dpram_master_pkg.sv
// Shared types and constants for the dual-port RAM burst master.
// Contents:
//   state_t       burst sequencer states
//   FIFO_DEPTH    entries in the read-return FIFO
//   FIFO_CNT_W    width of the FIFO occupancy count
//   RD_LATENCY    RAM read latency in cycles (registered read)
package dpram_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO catching RAM read returns ahead of the read-data stream.
// This is the only storage for read data in the burst master.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write one entry (ignored when full and not popping)
//   pop               remove the head entry (ignored when empty)
//   head              current head entry
//   count             number of valid entries (0..FIFO_DEPTH)
module rd_skid_fifo
    import dpram_master_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DWIDTH-1:0]     push_data,
    input  logic                  pop,
    output logic [DWIDTH-1:0]     head,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DWIDTH-1:0] entry [FIFO_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
    assign head    = entry[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_burst_master.sv
// Requester-side burst engine for one port of the dual-port RAM.
// Accepts a read/write burst command and sequences one RAM beat per cycle.
// Write beats arrive on a valid/ready stream; read beats leave on a
// valid/ready stream with full backpressure through a 2-entry FIFO.
// Build option: define DPRAM_MASTER_WRAP_CHECK_EN to reject bursts that run
// past the top of the address space (err + done pulse, no RAM access).
// Without it such bursts wrap modulo 2^AWIDTH and err is tied low.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len     burst command handshake and fields
//   wr_valid/ready/data/byteen         write-beat stream
//   rd_valid/ready/data                read-beat stream
//   done, err                          one-cycle completion / reject pulses
//   mem_address/wren/byteen/data       RAM port drive
//   mem_out                            RAM read data (1-cycle latency)
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WRITE | accepting write beats, one RAM write per accepted beat
// READ  | issuing RAM reads while FIFO credit remains
// DRAIN | all reads issued, waiting for returns to leave the FIFO
// DONE  | done pulse, back to IDLE
module dpram_burst_master
    import dpram_master_pkg::*;
#(
    parameter int AWIDTH   = 10,
    parameter int DWIDTH   = 32,
    parameter int LENWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AWIDTH-1:0]   cmd_addr,
    input  logic [LENWIDTH-1:0] cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DWIDTH-1:0]   wr_data,
    input  logic [DWIDTH/8-1:0] wr_byteen,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DWIDTH-1:0]   rd_data,
    output logic                done,
    output logic                err,
    output logic [AWIDTH-1:0]   mem_address,
    output logic                mem_wren,
    output logic [DWIDTH/8-1:0] mem_byteen,
    output logic [DWIDTH-1:0]   mem_data,
    input  logic [DWIDTH-1:0]   mem_out
);

    state_t                state;
    logic [AWIDTH-1:0]     addr;
    logic [LENWIDTH-1:0]   beats_left;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  rd_pop;
    logic                  rd_push;

    // Gating with reset keeps a burst abandoned by reset from writing the RAM
    // in the reset cycle itself.
    assign wr_fire     = wr_ready && wr_valid && !reset;
    assign mem_wren    = wr_fire;
    assign mem_address = addr;
    assign mem_data    = wr_fire ? wr_data   : '0;
    assign mem_byteen  = wr_fire ? wr_byteen : '0;

    assign rd_valid = (fifo_count != '0);
    assign rd_pop   = rd_valid && rd_ready;
    assign rd_push  = rd_pipe[RD_LATENCY-1];

    // Credit counts FIFO entries plus reads still in the RAM; a pop in this
    // cycle frees a slot, which is what sustains one beat per cycle.
    assign rd_issue = (state == READ) &&
                      ((int'(fifo_count) + $countones(rd_pipe) - int'(rd_pop)) < FIFO_DEPTH);

    rd_skid_fifo #(.DWIDTH(DWIDTH)) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_push),
        .push_data (mem_out),
        .pop       (rd_pop),
        .head      (rd_data),
        .count     (fifo_count)
    );

`ifdef DPRAM_MASTER_WRAP_CHECK_EN
    localparam int SUM_W = ((AWIDTH > LENWIDTH) ? AWIDTH : LENWIDTH) + 1;
    logic [SUM_W-1:0] burst_end;
    logic             wrap_bad;

    assign burst_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign wrap_bad  = burst_end > (SUM_W'(1) << AWIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && cmd_valid && (cmd_len != '0) && wrap_bad;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            wr_ready   <= 1'b0;
            done       <= 1'b0;
            addr       <= '0;
            beats_left <= '0;
            rd_pipe    <= '0;
        end else begin
            done    <= 1'b0;
            rd_pipe <= RD_LATENCY'({rd_pipe, rd_issue});
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        beats_left <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
`ifdef DPRAM_MASTER_WRAP_CHECK_EN
                        end else if (wrap_bad) begin
                            done <= 1'b1;
`endif
                        end else if (cmd_write) begin
                            state     <= WRITE;
                            cmd_ready <= 1'b0;
                            wr_ready  <= 1'b1;
                        end else begin
                            state     <= READ;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr       <= addr + AWIDTH'(1);
                        beats_left <= beats_left - LENWIDTH'(1);
                        if (beats_left == LENWIDTH'(1)) begin
                            state    <= DONE;
                            wr_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr       <= addr + AWIDTH'(1);
                        beats_left <= beats_left - LENWIDTH'(1);
                        if (beats_left == LENWIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((fifo_count == '0) && (rd_pipe == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    wr_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_burst_master.sv
// Directed bench for dpram_burst_master with a behavioural RAM model.
// Honors DPRAM_MASTER_WRAP_CHECK_EN for the wrap-around burst case.
module tb_dpram_burst_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_byteen;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_address;
    logic          mem_wren;
    logic [BW-1:0] mem_byteen;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    always #5 clk = ~clk;

    dpram_burst_master #(.AWIDTH(AW), .DWIDTH(DW), .LENWIDTH(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_byteen   (wr_byteen),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_byteen  (mem_byteen),
        .mem_data    (mem_data),
        .mem_out     (mem_out)
    );

    // RAM port model: registered read, read data updated only when not writing.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_byteen[b]) ram[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
            end
        end else begin
            ram_q <= ram[mem_address];
        end
    end
    assign mem_out = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    logic [31:0] w_be[$];
    int          w_cyc[$];
    logic [31:0] r_data[$];
    int          r_cyc[$];
    int          d_cyc[$];
    int          e_cyc[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wren) begin
                w_addr.push_back(32'(mem_address));
                w_data.push_back(mem_data);
                w_be.push_back(32'(mem_byteen));
                w_cyc.push_back(cyc);
            end
            if (rd_valid && rd_ready) begin
                r_data.push_back(rd_data);
                r_cyc.push_back(cyc);
            end
            if (done) d_cyc.push_back(cyc);
            if (err)  e_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        w_addr.delete(); w_data.delete(); w_be.delete(); w_cyc.delete();
        r_data.delete(); r_cyc.delete(); d_cyc.delete(); e_cyc.delete();
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_cmd_ready"},   64'(cmd_ready),   64'd1);
        chk({tag, "_wr_ready"},    64'(wr_ready),    64'd0);
        chk({tag, "_rd_valid"},    64'(rd_valid),    64'd0);
        chk({tag, "_done"},        64'(done),        64'd0);
        chk({tag, "_err"},         64'(err),         64'd0);
        chk({tag, "_mem_wren"},    64'(mem_wren),    64'd0);
        chk({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        chk({tag, "_mem_byteen"},  64'(mem_byteen),  64'd0);
        chk({tag, "_mem_data"},    64'(mem_data),    64'd0);
        chk({tag, "_rd_data"},     64'(rd_data),     64'd0);
    endtask

    // Offers a command at the current cycle; returns #1 after the accepting
    // edge with acc holding the index of the first post-acceptance cycle.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] n,
                            output int acc);
        logic r;
        int   g;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        g = 0;
        r = 1'b0;
        while (!r && g < 50) begin
            @(negedge clk);
            r = cmd_ready;
            tick();
            g++;
        end
        if (!r) chk("cmd_accept_timeout", 64'(g), 64'd0);
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    logic [DW-1:0] wd [0:15];

    // Streams n beats of wd[]; gappy drops wr_valid every third cycle.
    task automatic stream_write(input int n, input bit gappy, input logic [BW-1:0] be);
        int  idx;
        int  g;
        logic f;
        idx = 0;
        g = 0;
        while (idx < n && g < 200) begin
            wr_valid  = gappy ? ((g % 3) != 1) : 1'b1;
            wr_data   = wd[idx];
            wr_byteen = be;
            @(negedge clk);
            f = wr_valid && wr_ready;
            tick();
            if (f) idx++;
            g++;
        end
        wr_valid = 1'b0;
        if (idx != n) chk("wr_stream_timeout", 64'(idx), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_byteen = '0; rd_ready = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        tick();
        reset = 1'b0;
        tick();

        // 1: write len=4 at 0x010, no gaps
        clear_logs();
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        send_cmd(1'b1, 10'h010, 8'd4, acc);
        chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        stream_write(4, 1'b0, 4'hF);
        repeat (3) tick();
        chk("t1_nwrites", 64'(w_addr.size()), 64'd4);
        if (w_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t1_addr%0d", i), 64'(w_addr[i]), 64'(32'h010 + i));
                chk($sformatf("t1_data%0d", i), 64'(w_data[i]), 64'(32'h11 * (i + 1)));
                chk($sformatf("t1_cyc%0d", i),  64'(w_cyc[i]),  64'(acc + i));
            end
            chk("t1_be", 64'(w_be[0]), 64'hF);
        end
        chk("t1_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t1_done_cyc", 64'(d_cyc[0]), 64'(acc + 4));

        // 2: read len=4 at 0x010, consumer always ready
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h010, 8'd4, acc);
        repeat (12) tick();
        chk("t2_nbeats", 64'(r_data.size()), 64'd4);
        if (r_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_data%0d", i), 64'(r_data[i]), 64'(32'h11 * (i + 1)));
                chk($sformatf("t2_cyc%0d", i),  64'(r_cyc[i]),  64'(acc + 2 + i));
            end
        end
        chk("t2_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t2_done_cyc", 64'(d_cyc[0]), 64'(acc + 7));
        chk("t2_no_write", 64'(w_addr.size()), 64'd0);

        // 3a: write len=8 at 0x100 with wr_valid gaps
        clear_logs();
        rd_ready = 1'b0;
        wd[0] = 32'hDEAD_0001; wd[1] = 32'hBEEF_0002; wd[2] = 32'hCAFE_0003; wd[3] = 32'hF00D_0004;
        wd[4] = 32'h1234_5678; wd[5] = 32'h8765_4321; wd[6] = 32'h0F0F_F0F0; wd[7] = 32'hA5A5_5A5A;
        send_cmd(1'b1, 10'h100, 8'd8, acc);
        stream_write(8, 1'b1, 4'hF);
        repeat (3) tick();
        chk("t3w_nwrites", 64'(w_addr.size()), 64'd8);
        if (w_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t3w_addr%0d", i), 64'(w_addr[i]), 64'(32'h100 + i));
                chk($sformatf("t3w_data%0d", i), 64'(w_data[i]), 64'(wd[i]));
            end
            chk("t3w_last_cyc", 64'(w_cyc[7]), 64'(acc + 11));
        end
        chk("t3w_ndone", 64'(d_cyc.size()), 64'd1);

        // 3b: read len=8 with rd_ready pattern 1,0,0
        clear_logs();
        send_cmd(1'b0, 10'h100, 8'd8, acc);
        for (int i = 0; i < 40; i++) begin
            rd_ready = ((i % 3) == 0);
            tick();
        end
        rd_ready = 1'b0;
        chk("t3r_nbeats", 64'(r_data.size()), 64'd8);
        if (r_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t3r_data%0d", i), 64'(r_data[i]), 64'(wd[i]));
            end
            chk("t3r_first_cyc", 64'(r_cyc[0]), 64'(acc + 3));
        end
        chk("t3r_ndone", 64'(d_cyc.size()), 64'd1);
        chk("t3r_no_write", 64'(w_addr.size()), 64'd0);

        // 4: write len=3 at 0x3FE crosses the top of the address space
        clear_logs();
        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3;
        send_cmd(1'b1, 10'h3FE, 8'd3, acc);
`ifdef DPRAM_MASTER_WRAP_CHECK_EN
        wr_valid = 1'b1; wr_data = wd[0]; wr_byteen = 4'b1010;
        repeat (4) tick();
        wr_valid = 1'b0;
        chk("t4_nwrites", 64'(w_addr.size()), 64'd0);
        chk("t4_nerr", 64'(e_cyc.size()), 64'd1);
        if (e_cyc.size() == 1) chk("t4_err_cyc", 64'(e_cyc[0]), 64'(acc));
        chk("t4_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t4_done_cyc", 64'(d_cyc[0]), 64'(acc));
`else
        stream_write(3, 1'b0, 4'b1010);
        repeat (3) tick();
        chk("t4_nwrites", 64'(w_addr.size()), 64'd3);
        if (w_addr.size() == 3) begin
            chk("t4_addr0", 64'(w_addr[0]), 64'h3FE);
            chk("t4_addr1", 64'(w_addr[1]), 64'h3FF);
            chk("t4_addr2", 64'(w_addr[2]), 64'h000);
            chk("t4_data2", 64'(w_data[2]), 64'hA3);
            chk("t4_be2",   64'(w_be[2]),   64'b1010);
        end
        chk("t4_nerr", 64'(e_cyc.size()), 64'd0);
        chk("t4_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t4_done_cyc", 64'(d_cyc[0]), 64'(acc + 3));
`endif

        // 5: zero-length command is a no-op with a done pulse
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h020, 8'd0, acc);
        tick();
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) tick();
        chk("t5_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t5_done_cyc", 64'(d_cyc[0]), 64'(acc));
        chk("t5_no_write", 64'(w_addr.size()), 64'd0);
        chk("t5_no_read",  64'(r_data.size()), 64'd0);

        // 6: reset during beat 2 of a len=6 read, then a clean len=1 read
        clear_logs();
        send_cmd(1'b0, 10'h100, 8'd6, acc);
        tick();
        reset = 1'b1;
        tick();
        check_reset("t6_rst");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t6_no_beats", 64'(r_data.size()), 64'd0);
        chk("t6_no_done",  64'(d_cyc.size()), 64'd0);
        chk("t6_no_write", 64'(w_addr.size()), 64'd0);
        clear_logs();
        send_cmd(1'b0, 10'h100, 8'd1, acc);
        repeat (8) tick();
        chk("t6_nbeats", 64'(r_data.size()), 64'd1);
        if (r_data.size() == 1) begin
            chk("t6_data", 64'(r_data[0]), 64'hDEAD_0001);
            chk("t6_cyc",  64'(r_cyc[0]),  64'(acc + 2));
        end
        chk("t6_ndone", 64'(d_cyc.size()), 64'd1);
        if (d_cyc.size() == 1) chk("t6_done_cyc", 64'(d_cyc[0]), 64'(acc + 4));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
